// File: rtl/pl_hazard_ctrl_if.sv
// Pipeline-register fields consumed by the hazard controller and the controls it returns.
// The master side is the pipeline datapath; the slave side is pl_hazard_ctrl.
interface pl_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       Rn_dec;
  logic [4:0]       Rm_dec;
  logic             use_a;
  logic             use_b;
  logic             blt_dec;
  logic             brtaken_dec;
  logic [4:0]       Rd_ex;
  logic             regwr_ex;
  logic             mem2reg_ex;
  logic             setflags_ex;
  logic [4:0]       Rd_mem;
  logic             regwr_mem;
  logic [4:0]       Rd_wb;
  logic             regwr_wb;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             pc_hold;
  logic             ifrf_hold;
  logic             rfex_bubble;
  logic             ifrf_flush;
  logic             hazard_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rn_dec, Rm_dec, use_a, use_b, blt_dec, brtaken_dec,
    output Rd_ex, regwr_ex, mem2reg_ex, setflags_ex,
    output Rd_mem, regwr_mem, Rd_wb, regwr_wb,
    input  fwd_a, fwd_b, pc_hold, ifrf_hold, rfex_bubble, ifrf_flush,
    input  hazard_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rn_dec, Rm_dec, use_a, use_b, blt_dec, brtaken_dec,
    input  Rd_ex, regwr_ex, mem2reg_ex, setflags_ex,
    input  Rd_mem, regwr_mem, Rd_wb, regwr_wb,
    output fwd_a, fwd_b, pc_hold, ifrf_hold, rfex_bubble, ifrf_flush,
    output hazard_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pl_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding selects, load-use/flag stalls,
// taken-branch flush of if_2_rf, and saturating stall/flush statistics.
module pl_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned STALL_MAX = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  pl_hazard_ctrl_if.slave     hz
);

  localparam int unsigned RunW = $clog2(STALL_MAX + 1);
  localparam logic [RunW-1:0] RunMax   = RunW'(STALL_MAX);
  localparam logic [RunW-1:0] RunLast  = RunW'(STALL_MAX - 1);
  localparam logic [2:0]      FlushInit = 3'(FLUSH_CYC - 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, flag_haz, stall, flush;

  // X31 is the zero register, so it never sources a forward.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] rd_ex, input logic wr_ex, input logic ld_ex,
    input logic [4:0] rd_mem, input logic wr_mem,
    input logic [4:0] rd_wb, input logic wr_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd31) begin
      if (wr_ex && rd_ex == src && !ld_ex) sel = 2'b01;
      else if (wr_mem && rd_mem == src)    sel = 2'b10;
      else if (wr_wb && rd_wb == src)      sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = hz.mem2reg_ex && hz.regwr_ex && hz.Rd_ex != 5'd31 &&
               ((hz.use_a && hz.Rd_ex == hz.Rn_dec) || (hz.use_b && hz.Rd_ex == hz.Rm_dec));
    flag_haz = hz.blt_dec && hz.setflags_ex;
    // Decode holds a squashed NOP during FLUSH, so nothing there can stall.
    stall    = (load_use || flag_haz) && state_q == StRun;
    flush    = state_q == StFlush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      run_q       <= run_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StRun: begin
        // A stalled branch is re-evaluated once the stall clears.
        if (hz.brtaken_dec && !stall) begin
          state_d = StFlush;
          fcnt_d  = FlushInit;
        end
      end
      StFlush: begin
        if (fcnt_q == 3'd0) state_d = StRun;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      default: state_d = StRun;
    endcase

    run_d = '0;
    if (stall) run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
    err_d = err_q || (stall && run_q >= RunLast);

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_comb begin
    hz.fwd_a       = 2'b00;
    hz.fwd_b       = 2'b00;
    hz.pc_hold     = 1'b0;
    hz.ifrf_hold   = 1'b0;
    hz.rfex_bubble = 1'b0;
    hz.ifrf_flush  = 1'b0;
    if (reset) begin
      hz.fwd_a       = fwd_sel(hz.Rn_dec, hz.Rd_ex, hz.regwr_ex, hz.mem2reg_ex,
                               hz.Rd_mem, hz.regwr_mem, hz.Rd_wb, hz.regwr_wb);
      hz.fwd_b       = fwd_sel(hz.Rm_dec, hz.Rd_ex, hz.regwr_ex, hz.mem2reg_ex,
                               hz.Rd_mem, hz.regwr_mem, hz.Rd_wb, hz.regwr_wb);
      hz.pc_hold     = stall;
      hz.ifrf_hold   = stall;
      hz.rfex_bubble = stall;
      hz.ifrf_flush  = flush;
    end
    hz.hazard_err = err_q;
    hz.stall_cnt  = stall_cnt_q;
    hz.flush_cnt  = flush_cnt_q;
  end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl: forwarding priority, load-use/flag stalls, branch flush,
// sticky hazard_err, counter saturation and asynchronous reset.
module tb_pl_hazard_ctrl;

  localparam int unsigned CntW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pl_hazard_ctrl_if #(.CNT_W(CntW)) hz ();

  pl_hazard_ctrl #(
    .FLUSH_CYC(2),
    .STALL_MAX(4),
    .CNT_W    (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.Rn_dec = '0; hz.Rm_dec = '0; hz.use_a = 0; hz.use_b = 0;
    hz.blt_dec = 0; hz.brtaken_dec = 0;
    hz.Rd_ex = '0; hz.regwr_ex = 0; hz.mem2reg_ex = 0; hz.setflags_ex = 0;
    hz.Rd_mem = '0; hz.regwr_mem = 0; hz.Rd_wb = '0; hz.regwr_wb = 0;
  endtask

  task automatic set_load_use();
    hz.Rd_ex = 5'd3; hz.regwr_ex = 1; hz.mem2reg_ex = 1; hz.Rn_dec = 5'd3; hz.use_a = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clear_inputs();
    // Stimulus that would forward and stall if not held in reset.
    set_load_use();
    hz.Rd_mem = 5'd4; hz.regwr_mem = 1; hz.Rm_dec = 5'd4;
    #2;
    check("rst_fwd_a", 32'(hz.fwd_a), 32'd0);
    check("rst_fwd_b", 32'(hz.fwd_b), 32'd0);
    check("rst_pc_hold", 32'(hz.pc_hold), 32'd0);
    check("rst_flush", 32'(hz.ifrf_flush), 32'd0);
    check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("rst_hazard_err", 32'(hz.hazard_err), 32'd0);
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();

    // Load-use: LDUR X3 in EX, ADD reads X3.
    set_load_use();
    #1;
    check("lu_pc_hold", 32'(hz.pc_hold), 32'd1);
    check("lu_ifrf_hold", 32'(hz.ifrf_hold), 32'd1);
    check("lu_bubble", 32'(hz.rfex_bubble), 32'd1);
    check("lu_fwd_a_ex_load", 32'(hz.fwd_a), 32'd0);
    tick();
    hz.Rd_ex = '0; hz.regwr_ex = 0; hz.mem2reg_ex = 0;
    hz.Rd_mem = 5'd3; hz.regwr_mem = 1;
    #1;
    check("lu_released", 32'(hz.pc_hold), 32'd0);
    check("lu_fwd_a_mem", 32'(hz.fwd_a), 32'd2);
    check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
    clear_inputs();

    // Forwarding priority.
    hz.Rd_ex = 5'd2; hz.regwr_ex = 1; hz.Rd_mem = 5'd2; hz.regwr_mem = 1; hz.Rn_dec = 5'd2;
    #1;
    check("fwd_ex_prio", 32'(hz.fwd_a), 32'd1);
    clear_inputs();
    hz.Rd_ex = 5'd31; hz.regwr_ex = 1; hz.Rd_mem = 5'd31; hz.regwr_mem = 1;
    hz.Rd_wb = 5'd31; hz.regwr_wb = 1; hz.Rm_dec = 5'd31;
    #1;
    check("fwd_x31", 32'(hz.fwd_b), 32'd0);
    clear_inputs();
    hz.Rd_wb = 5'd7; hz.regwr_wb = 1; hz.Rm_dec = 5'd7;
    #1;
    check("fwd_wb", 32'(hz.fwd_b), 32'd3);
    hz.Rd_mem = 5'd7; hz.regwr_mem = 1;
    #1;
    check("fwd_mem_over_wb", 32'(hz.fwd_b), 32'd2);
    hz.regwr_mem = 0; hz.regwr_wb = 0;
    #1;
    check("fwd_none", 32'(hz.fwd_b), 32'd0);
    clear_inputs();

    // Taken branch, FLUSH_CYC=2, branch held high through the flush.
    hz.brtaken_dec = 1;
    #1;
    check("br_run_noflush", 32'(hz.ifrf_flush), 32'd0);
    tick();
    check("br_flush1", 32'(hz.ifrf_flush), 32'd1);
    tick();
    check("br_flush2", 32'(hz.ifrf_flush), 32'd1);
    set_load_use();
    #1;
    check("br_no_stall_in_flush", 32'(hz.pc_hold), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("br_flush_done", 32'(hz.ifrf_flush), 32'd0);
    check("br_flush_cnt", 32'(hz.flush_cnt), 32'd2);
    check("br_stall_cnt_kept", 32'(hz.stall_cnt), 32'd1);

    // Flag hazard with taken branch: stall wins, flush next cycle.
    hz.blt_dec = 1; hz.setflags_ex = 1; hz.brtaken_dec = 1;
    #1;
    check("flag_stall", 32'(hz.pc_hold), 32'd1);
    check("flag_noflush", 32'(hz.ifrf_flush), 32'd0);
    tick();
    hz.setflags_ex = 0;
    #1;
    check("flag_released", 32'(hz.pc_hold), 32'd0);
    check("flag_still_run", 32'(hz.ifrf_flush), 32'd0);
    tick();
    check("flag_flush1", 32'(hz.ifrf_flush), 32'd1);
    tick();
    check("flag_flush2", 32'(hz.ifrf_flush), 32'd1);
    hz.brtaken_dec = 0; hz.blt_dec = 0;
    tick();
    check("flag_flush_end", 32'(hz.ifrf_flush), 32'd0);
    check("flag_flush_cnt", 32'(hz.flush_cnt), 32'd4);
    check("flag_stall_cnt", 32'(hz.stall_cnt), 32'd2);

    // Four consecutive stall cycles set the sticky error.
    set_load_use();
    tick(); tick(); tick();
    check("err_before", 32'(hz.hazard_err), 32'd0);
    tick();
    check("err_set", 32'(hz.hazard_err), 32'd1);
    clear_inputs();
    tick();
    check("err_sticky", 32'(hz.hazard_err), 32'd1);
    check("err_stall_cnt", 32'(hz.stall_cnt), 32'd6);

    // Saturation of the 4-bit stall counter.
    set_load_use();
    for (int i = 0; i < 12; i++) tick();
    check("sat_reach", 32'(hz.stall_cnt), 32'd15);
    tick(); tick();
    check("sat_hold", 32'(hz.stall_cnt), 32'd15);
    clear_inputs();
    tick();

    // Asynchronous reset during the first FLUSH cycle.
    hz.brtaken_dec = 1;
    tick();
    hz.brtaken_dec = 0;
    check("ar_in_flush", 32'(hz.ifrf_flush), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("ar_flush", 32'(hz.ifrf_flush), 32'd0);
    check("ar_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    check("ar_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    check("ar_hazard_err", 32'(hz.hazard_err), 32'd0);
    #1 reset = 1'b1;
    tick();
    check("ar_run_after", 32'(hz.ifrf_flush), 32'd0);
    hz.brtaken_dec = 1;
    tick();
    hz.brtaken_dec = 0;
    check("ar_flush_again", 32'(hz.ifrf_flush), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
